// File: rtl/sseg_to_bcd_monitor.sv
// -----------------------------------------------------------------------------
// sseg_to_bcd_monitor
//
// Purpose:
//   Watches the active-low, multiplexed 4-digit seven-segment display lines
//   and recovers the digits being shown. The 11 pin lines are synchronized.
//   Scan transitions and ghosting are rejected by requiring STABLE_CYCLES
//   identical consecutive samples. Each stable pattern is then decoded back
//   to BCD into the digit slot selected by its single active anode.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous, active-high reset
//   sseg   - segment lines a..g on bits 0..6, active-low
//   an     - anode lines, active-low; an[i] selects digit i
//   bcd    - recovered digits, bcd[4i+3:4i] = digit i (4'hF when blank)
//   valid  - valid[i]: digit i holds a decoded 0-9 value
//   err    - err[i]: last accepted pattern on digit i was not a legal code
//   update - one-cycle pulse whenever bcd/valid/err changes
// -----------------------------------------------------------------------------
module sseg_to_bcd_monitor #(
  parameter int unsigned STABLE_CYCLES = 4  // legal range 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  sseg,
  input  logic [3:0]  an,
  output logic [15:0] bcd,
  output logic [3:0]  valid,
  output logic [3:0]  err,
  output logic        update
);

  localparam logic [7:0]  THRESH    = 8'(STABLE_CYCLES);
  localparam logic [10:0] DARK_WORD = '1;

  typedef enum logic {
    TRACK,   // counting identical samples of the current word
    LOCKED   // current word already accepted; waiting for it to change
  } state_e;

  typedef enum logic [1:0] {
    SEG_DIGIT,
    SEG_BLANK,
    SEG_ILLEGAL
  } seg_kind_e;

  typedef struct packed {
    seg_kind_e  kind;
    logic [3:0] digit;
  } seg_decode_t;

  // Inverse of the active-low seven-segment font.
  function automatic seg_decode_t decode_seg(input logic [6:0] seg);
    seg_decode_t r;
    r.kind  = SEG_DIGIT;
    r.digit = 4'h0;
    case (seg)
      7'h40: r.digit = 4'd0;
      7'h79: r.digit = 4'd1;
      7'h24: r.digit = 4'd2;
      7'h30: r.digit = 4'd3;
      7'h19: r.digit = 4'd4;
      7'h12: r.digit = 4'd5;
      7'h02: r.digit = 4'd6;
      7'h78: r.digit = 4'd7;
      7'h00: r.digit = 4'd8;
      7'h18: r.digit = 4'd9;
      7'h7F: begin
        r.kind  = SEG_BLANK;
        r.digit = 4'hF;
      end
      default: r.kind = SEG_ILLEGAL;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [10:0] sync1_q, sync1_d;
  logic [10:0] sync2_q, sync2_d;
  logic [10:0] last_q,  last_d;   // sync2 one cycle ago, for change detection
  logic [7:0]  cnt_q,   cnt_d;
  state_e      state_q, state_d;
  logic [15:0] bcd_q,   bcd_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  err_q,   err_d;
  logic        update_q, update_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic        word_changed;
  logic        accept;
  logic [3:0]  anode_sel;
  logic        one_anode;
  logic [1:0]  digit_idx;
  seg_decode_t dec;
  logic [3:0]  new_digit;
  logic        new_valid;
  logic        new_err;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    sync1_d   = {an, sseg};
    sync2_d   = sync1_q;
    last_d    = sync2_q;
    bcd_d     = bcd_q;
    valid_d   = valid_q;
    err_d     = err_q;
    update_d  = 1'b0;
    digit_idx = 2'd0;
    new_digit = 4'hF;
    new_valid = 1'b0;
    new_err   = 1'b0;

    word_changed = (sync2_q != last_q);

    // A change restarts the run at 1; otherwise count up and saturate.
    if (word_changed)         cnt_d = 8'd1;
    else if (cnt_q >= THRESH) cnt_d = THRESH;
    else                      cnt_d = cnt_q + 8'd1;

    // In LOCKED the count sits at the threshold, so only a change (which
    // reloads 1) can reach it again; that only happens when THRESH is 1.
    accept = (cnt_d == THRESH) && ((state_q == TRACK) || word_changed);

    if (accept)            state_d = LOCKED;
    else if (word_changed) state_d = TRACK;
    else                   state_d = state_q;

    anode_sel = ~sync2_q[10:7];
    one_anode = $onehot(anode_sel);
    for (int i = 0; i < 4; i++) begin
      if (anode_sel[i]) digit_idx = 2'(i);
    end

    dec = decode_seg(sync2_q[6:0]);

    if (accept && one_anode) begin
      new_digit = bcd_q[{digit_idx, 2'b00} +: 4];
      unique case (dec.kind)
        SEG_DIGIT: begin
          new_digit = dec.digit;
          new_valid = 1'b1;
        end
        SEG_BLANK: new_digit = 4'hF;
        default:   new_err   = 1'b1;  // digit keeps its previous value
      endcase

      bcd_d[{digit_idx, 2'b00} +: 4] = new_digit;
      valid_d[digit_idx]             = new_valid;
      err_d[digit_idx]               = new_err;
      update_d = (bcd_d != bcd_q) || (valid_d != valid_q) || (err_d != err_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers; every synchronizer flop resets to the dark (all-ones) level.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs from the same clock edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= DARK_WORD;
      sync2_q  <= DARK_WORD;
      last_q   <= DARK_WORD;
      cnt_q    <= 8'd0;
      state_q  <= TRACK;
      bcd_q    <= 16'hFFFF;
      valid_q  <= 4'h0;
      err_q    <= 4'h0;
      update_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      update_q <= update_d;
    end
  end

  assign bcd    = bcd_q;
  assign valid  = valid_q;
  assign err    = err_q;
  assign update = update_q;

endmodule
